// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control bundle layout, ALU op encodings, register constants.
package mips_pkg;

  localparam int CTRL_W = 8;

  // Bit offsets inside the control bundle {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0]}
  localparam int CTRL_ALU_OP_LO  = 0;
  localparam int CTRL_REG_DST    = 2;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_REG_WRITE  = 7;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
import mips_pkg::*;

module hazard_detect #(
  parameter int ADDR_W = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_dst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              flush,
  input  logic              stall_in,
  output logic              lu,
  output logic              id_stall
);

  assign lu = ex_valid && ex_mem_read && (ex_dst != ADDR_W'(REG_ZERO)) && id_valid &&
              ((ex_dst == id_rs) || (ex_dst == id_rt));

  // A taken branch kills the dependent instruction, so no need to hold ID for it
  assign id_stall = stall_in || (lu && !flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID bypass, load-use bubble insertion and downstream hold.
// Optional feature macro: ID_WB_BYPASS_EN (WB->ID operand bypass).
import mips_pkg::*;

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              stall_in,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t               ex_q, ex_d;
  logic              lu;
  logic [DATA_W-1:0] opa, opb;

`ifdef ID_WB_BYPASS_EN
  // Register file writes on the same edge we capture on, so forward the write-back value here
  assign opa = (wb_write && wb_addr != ADDR_W'(REG_ZERO) && wb_addr == id_rs) ? wb_data : id_rdata1;
  assign opb = (wb_write && wb_addr != ADDR_W'(REG_ZERO) && wb_addr == id_rt) ? wb_data : id_rdata2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_write, wb_addr, wb_data};
  assign opa = id_rdata1;
  assign opb = id_rdata2;
`endif

  hazard_detect #(.ADDR_W(ADDR_W)) u_hazard (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl[CTRL_MEM_READ]),
    .ex_dst      (ex_q.dst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .flush       (flush),
    .stall_in    (stall_in),
    .lu          (lu),
    .id_stall    (id_stall)
  );

  always_comb begin
    ex_d       = '0;
    ex_d.valid = id_valid;
    ex_d.rs    = id_rs;
    ex_d.rt    = id_rt;
    ex_d.dst   = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
    ex_d.a     = opa;
    ex_d.b     = opb;
    ex_d.imm   = id_imm;
    ex_d.ctrl  = id_valid ? id_ctrl : '0;
  end

  // Priority: downstream hold, then flush/load-use bubble, then capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ex_q <= '0;
    else if (stall_in)       ex_q <= ex_q;
    else if (flush || lu)    ex_q <= '0;
    else                     ex_q <= ex_d;
  end

  assign ex_valid = ex_q.valid;
  assign ex_rs    = ex_q.rs;
  assign ex_rt    = ex_q.rt;
  assign ex_dst   = ex_q.dst;
  assign ex_a     = ex_q.a;
  assign ex_b     = ex_q.b;
  assign ex_imm   = ex_q.imm;
  assign ex_ctrl  = ex_q.ctrl;

endmodule
